cpu_lockstep_chk: RTL and testbench

Consumes the CPU bus transactions produced by the reference model and the DUV CPU, both running on the same clock. Buffers each stream in its own small FIFO, compares transactions in order, and counts matches and mismatches. Captures the first divergence and flags overflow and timeout errors. It sits directly downstream of both cpu/mem pairs and replaces ad-hoc bench comparison with a synthesizable checker.

---
 rtl/cpu_lockstep_chk_pkg.sv | 34 +++
 rtl/cpu_lockstep_chk_fifo.sv | 78 +++++++
 rtl/cpu_lockstep_chk.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_lockstep_chk.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_lockstep_chk_pkg.sv
// ---------------------------------------------------------------------------
// cpu_lockstep_chk_pkg
// Shared types and constants for the CPU lockstep checker:
//   bus_txn_t  - one bus transaction {rw, addr, data}, 25 bits
//   ls_state_e - checker state (LS_RUN comparing, LS_HALT frozen)
//   LS_MIS_MAX - saturation value of the mismatch counter
//   sat_inc16  - saturating 16-bit increment
// ---------------------------------------------------------------------------
package cpu_lockstep_chk_pkg;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_txn_t;

  typedef enum logic {
    LS_RUN  = 1'b0,
    LS_HALT = 1'b1
  } ls_state_e;

  localparam logic [15:0] LS_MIS_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == LS_MIS_MAX) begin
      res = LS_MIS_MAX;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_lockstep_chk_fifo.sv
// ---------------------------------------------------------------------------
// lockstep_fifo
// First-word-fall-through FIFO holding one side's bus transactions.
//   clk_i   - clock
//   rst_i   - synchronous active-high reset (empties the FIFO)
//   push_i  - write din_i; ignored when full unless popping the same cycle
//   pop_i   - drop the head entry; ignored when empty
//   din_i   - transaction to write
//   dout_o  - head entry, valid whenever empty_o is low
//   full_o  - DEPTH entries held
//   empty_o - no entries held
// ---------------------------------------------------------------------------
module lockstep_fifo
  import cpu_lockstep_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  bus_txn_t din_i,
  output bus_txn_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  bus_txn_t    mem_q [DEPTH];
  logic        do_push_s;
  logic        do_pop_s;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign do_pop_s  = pop_i & ~empty_o;
  // A full FIFO may accept a push only when the head leaves in the same cycle.
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign dout_o    = mem_q[rptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push_s) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= {(AW+1){1'b0}};
      rptr_q <= {(AW+1){1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/cpu_lockstep_chk.sv
// ---------------------------------------------------------------------------
// cpu_lockstep_chk
// Buffers the DUV and reference bus streams in two FIFOs and compares them
// in order, counting compares and mismatches, capturing the first
// divergence and flagging overflow and timeout.
//   clk_i, rst_i, clr_i      - clock, sync reset, sync soft clear (same effect)
//   en_i                     - capture enable for both push streams
//   duv_*_i / ref_*_i        - vld strobe plus {rw, addr, data} per side
//   cmp_cnt_o                - transactions compared (wraps at 2^32)
//   mis_cnt_o                - mismatches (saturating)
//   mis_flag_o/ovf_flag_o/tmo_flag_o - sticky error flags
//   halted_o                 - checker is in LS_HALT
//   first_mis_idx_o, first_duv_txn_o, first_ref_txn_o - first mismatch capture
// ---------------------------------------------------------------------------
module cpu_lockstep_chk
  import cpu_lockstep_chk_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          HALT_ON_MIS = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        duv_vld_i,
  input  logic [15:0] duv_addr_i,
  input  logic [7:0]  duv_data_i,
  input  logic        duv_rw_i,
  input  logic        ref_vld_i,
  input  logic [15:0] ref_addr_i,
  input  logic [7:0]  ref_data_i,
  input  logic        ref_rw_i,
  output logic [31:0] cmp_cnt_o,
  output logic [15:0] mis_cnt_o,
  output logic        mis_flag_o,
  output logic        ovf_flag_o,
  output logic        tmo_flag_o,
  output logic        halted_o,
  output logic [31:0] first_mis_idx_o,
  output logic [24:0] first_duv_txn_o,
  output logic [24:0] first_ref_txn_o
);

  localparam int unsigned       TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT - 1);

  ls_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      cmp_cnt_q, cmp_cnt_d;
  logic [15:0]      mis_cnt_q, mis_cnt_d;
  logic             mis_flag_q, mis_flag_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic [31:0]      first_idx_q, first_idx_d;
  bus_txn_t         first_duv_q, first_duv_d;
  bus_txn_t         first_ref_q, first_ref_d;

  logic     fifo_rst_s;
  logic     duv_push_s, ref_push_s;
  logic     duv_full_s, ref_full_s;
  logic     duv_empty_s, ref_empty_s;
  bus_txn_t duv_din_s, ref_din_s;
  bus_txn_t duv_head_s, ref_head_s;
  logic     do_cmp_s;
  logic     mis_s;
  logic     ovf_s;
  logic     tmo_hit_s;

  assign fifo_rst_s = rst_i | clr_i;
  assign duv_push_s = duv_vld_i & en_i;
  assign ref_push_s = ref_vld_i & en_i;
  assign duv_din_s  = '{rw: duv_rw_i, addr: duv_addr_i, data: duv_data_i};
  assign ref_din_s  = '{rw: ref_rw_i, addr: ref_addr_i, data: ref_data_i};

  lockstep_fifo #(.DEPTH(DEPTH)) u_duv_fifo (
    .clk_i   (clk_i),
    .rst_i   (fifo_rst_s),
    .push_i  (duv_push_s),
    .pop_i   (do_cmp_s),
    .din_i   (duv_din_s),
    .dout_o  (duv_head_s),
    .full_o  (duv_full_s),
    .empty_o (duv_empty_s)
  );

  lockstep_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
    .clk_i   (clk_i),
    .rst_i   (fifo_rst_s),
    .push_i  (ref_push_s),
    .pop_i   (do_cmp_s),
    .din_i   (ref_din_s),
    .dout_o  (ref_head_s),
    .full_o  (ref_full_s),
    .empty_o (ref_empty_s)
  );

  // Both heads leave together, so a side only overflows when no compare runs.
  assign do_cmp_s  = (state_q == LS_RUN) & ~duv_empty_s & ~ref_empty_s;
  assign mis_s     = do_cmp_s & (duv_head_s != ref_head_s);
  assign ovf_s     = (duv_push_s & duv_full_s & ~do_cmp_s) |
                     (ref_push_s & ref_full_s & ~do_cmp_s);
  // Counter reaching TIMEOUT on this edge means TIMEOUT cycles of one-sided lead.
  assign tmo_hit_s = (state_q == LS_RUN) & (duv_empty_s ^ ref_empty_s) &
                     (tmo_q == TMO_LIMIT);

  // Next-state for the FSM, counters, flags and first-mismatch capture.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    cmp_cnt_d   = cmp_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    mis_flag_d  = mis_flag_q;
    ovf_flag_d  = ovf_flag_q | ovf_s;
    tmo_flag_d  = tmo_flag_q | tmo_hit_s;
    first_idx_d = first_idx_q;
    first_duv_d = first_duv_q;
    first_ref_d = first_ref_q;

    if (do_cmp_s) begin
      cmp_cnt_d = cmp_cnt_q + 32'd1;
      if (mis_s) begin
        mis_cnt_d  = sat_inc16(mis_cnt_q);
        mis_flag_d = 1'b1;
        if (!mis_flag_q) begin
          first_idx_d = cmp_cnt_q;
          first_duv_d = duv_head_s;
          first_ref_d = ref_head_s;
        end else begin
          first_idx_d = first_idx_q;
        end
      end else begin
        mis_cnt_d = mis_cnt_q;
      end
    end else begin
      cmp_cnt_d = cmp_cnt_q;
    end

    case (state_q)
      LS_RUN: begin
        // The lead counter only runs while exactly one side holds data.
        if (do_cmp_s || (duv_empty_s && ref_empty_s)) begin
          tmo_d = {TMO_W{1'b0}};
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
        if (ovf_s || tmo_hit_s || (mis_s && HALT_ON_MIS)) begin
          state_d = LS_HALT;
        end else begin
          state_d = LS_RUN;
        end
      end
      LS_HALT: begin
        state_d = LS_HALT;
        tmo_d   = tmo_q;
      end
      default: begin
        state_d = LS_HALT;
        tmo_d   = tmo_q;
      end
    endcase
  end

  // All checker state; rst and clr both clear it and take priority.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q     <= LS_RUN;
      tmo_q       <= {TMO_W{1'b0}};
      cmp_cnt_q   <= 32'd0;
      mis_cnt_q   <= 16'd0;
      mis_flag_q  <= 1'b0;
      ovf_flag_q  <= 1'b0;
      tmo_flag_q  <= 1'b0;
      first_idx_q <= 32'd0;
      first_duv_q <= 25'd0;
      first_ref_q <= 25'd0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      cmp_cnt_q   <= cmp_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      mis_flag_q  <= mis_flag_d;
      ovf_flag_q  <= ovf_flag_d;
      tmo_flag_q  <= tmo_flag_d;
      first_idx_q <= first_idx_d;
      first_duv_q <= first_duv_d;
      first_ref_q <= first_ref_d;
    end
  end

  assign cmp_cnt_o       = cmp_cnt_q;
  assign mis_cnt_o       = mis_cnt_q;
  assign mis_flag_o      = mis_flag_q;
  assign ovf_flag_o      = ovf_flag_q;
  assign tmo_flag_o      = tmo_flag_q;
  assign halted_o        = (state_q == LS_HALT);
  assign first_mis_idx_o = first_idx_q;
  assign first_duv_txn_o = first_duv_q;
  assign first_ref_txn_o = first_ref_q;

endmodule

// File: tb/tb_cpu_lockstep_chk.sv
// ---------------------------------------------------------------------------
// tb_cpu_lockstep_chk
// Two checker instances share all inputs: index 0 halts on mismatch,
// index 1 keeps comparing. Stimulus pushes expected status snapshots and
// expected per-compare counts into queues; a negedge monitor pops and
// compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_cpu_lockstep_chk;
  import cpu_lockstep_chk_pkg::*;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic duv_vld, ref_vld;
  bus_txn_t duv_t, ref_t;

  logic [1:0][31:0] cmp_cnt;
  logic [1:0][15:0] mis_cnt;
  logic [1:0]       mis_flag, ovf_flag, tmo_flag, halted;
  logic [1:0][31:0] first_idx;
  logic [1:0][24:0] first_duv, first_ref;

  always #5 clk = ~clk;

  cpu_lockstep_chk #(.DEPTH(8), .TIMEOUT(64), .HALT_ON_MIS(1'b1)) dut_h (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .duv_vld_i(duv_vld), .duv_addr_i(duv_t.addr), .duv_data_i(duv_t.data), .duv_rw_i(duv_t.rw),
    .ref_vld_i(ref_vld), .ref_addr_i(ref_t.addr), .ref_data_i(ref_t.data), .ref_rw_i(ref_t.rw),
    .cmp_cnt_o(cmp_cnt[0]), .mis_cnt_o(mis_cnt[0]), .mis_flag_o(mis_flag[0]),
    .ovf_flag_o(ovf_flag[0]), .tmo_flag_o(tmo_flag[0]), .halted_o(halted[0]),
    .first_mis_idx_o(first_idx[0]), .first_duv_txn_o(first_duv[0]), .first_ref_txn_o(first_ref[0])
  );

  cpu_lockstep_chk #(.DEPTH(8), .TIMEOUT(64), .HALT_ON_MIS(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .duv_vld_i(duv_vld), .duv_addr_i(duv_t.addr), .duv_data_i(duv_t.data), .duv_rw_i(duv_t.rw),
    .ref_vld_i(ref_vld), .ref_addr_i(ref_t.addr), .ref_data_i(ref_t.data), .ref_rw_i(ref_t.rw),
    .cmp_cnt_o(cmp_cnt[1]), .mis_cnt_o(mis_cnt[1]), .mis_flag_o(mis_flag[1]),
    .ovf_flag_o(ovf_flag[1]), .tmo_flag_o(tmo_flag[1]), .halted_o(halted[1]),
    .first_mis_idx_o(first_idx[1]), .first_duv_txn_o(first_duv[1]), .first_ref_txn_o(first_ref[1])
  );

  typedef struct {
    int           inst;
    string        name;
    logic [133:0] exp;
  } snap_t;

  snap_t        snap_q[$];
  logic [47:0]  cmp_q[$];   // {cmp_cnt, mis_cnt} expected after each compare of dut_n
  int           n_total = 0;
  int           n_pass  = 0;

  // Bench model of dut_n's buffered streams
  bus_txn_t     mdl_duv[$];
  bus_txn_t     mdl_ref[$];
  logic [31:0]  m_cmp;
  logic [15:0]  m_mis;

  function automatic logic [133:0] mk(input logic [31:0] c, input logic [15:0] m,
                                      input logic mf, input logic of, input logic tf,
                                      input logic hl, input logic [31:0] idx,
                                      input logic [24:0] fd, input logic [24:0] fr);
    return {c, m, mf, of, tf, hl, idx, fd, fr};
  endfunction

  // Monitor: compares queued snapshots and each compare event of dut_n.
  snap_t        ms;
  logic [133:0] act;
  logic [47:0]  ce;
  logic [31:0]  last_cmp = 32'd0;
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      ms  = snap_q.pop_front();
      act = {cmp_cnt[ms.inst], mis_cnt[ms.inst], mis_flag[ms.inst], ovf_flag[ms.inst],
             tmo_flag[ms.inst], halted[ms.inst], first_idx[ms.inst],
             first_duv[ms.inst], first_ref[ms.inst]};
      n_total++;
      if (act !== ms.exp)
        $display("FAIL %s inst%0d: got %h expected %h", ms.name, ms.inst, act, ms.exp);
      else
        n_pass++;
    end
    if (cmp_cnt[1] !== last_cmp) begin
      if (cmp_cnt[1] !== 32'd0) begin
        n_total++;
        if (cmp_q.size() == 0) begin
          $display("FAIL compare_evt: got unexpected cmp_cnt %0d expected no compare", cmp_cnt[1]);
        end else begin
          ce = cmp_q.pop_front();
          if ({cmp_cnt[1], mis_cnt[1]} !== ce)
            $display("FAIL compare_evt: got cmp=%0d mis=%0d expected cmp=%0d mis=%0d",
                     cmp_cnt[1], mis_cnt[1], ce[47:16], ce[15:0]);
          else
            n_pass++;
        end
      end
      last_cmp = cmp_cnt[1];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int inst, input string name, input logic [133:0] e);
    snap_t s;
    s.inst = inst;
    s.name = name;
    s.exp  = e;
    snap_q.push_back(s);
  endtask

  // One cycle of stimulus; the model tracks what dut_n should compare.
  task automatic step(input logic dv, input bus_txn_t d, input logic rv, input bus_txn_t r);
    bus_txn_t a, b;
    duv_vld = dv; duv_t = d;
    ref_vld = rv; ref_t = r;
    cyc();
    if (dv && en) mdl_duv.push_back(d);
    if (rv && en) mdl_ref.push_back(r);
    while (mdl_duv.size() > 0 && mdl_ref.size() > 0) begin
      a = mdl_duv.pop_front();
      b = mdl_ref.pop_front();
      m_cmp = m_cmp + 32'd1;
      if (a != b) m_mis = m_mis + 16'd1;
      cmp_q.push_back({m_cmp, m_mis});
    end
    duv_vld = 1'b0;
    ref_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 25'd0, 1'b0, 25'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    mdl_duv.delete();
    mdl_ref.delete();
    m_cmp = 32'd0;
    m_mis = 16'd0;
  endtask

  function automatic bus_txn_t txn(input int i);
    bus_txn_t t;
    t.rw   = i[0];
    t.addr = 16'h1000 + 16'(i);
    t.data = 8'hA0 + 8'(i);
    return t;
  endfunction

  bus_txn_t d, r;
  logic [133:0] zero_v;

  initial begin
    zero_v = mk(32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0);
    rst = 1'b1; en = 1'b1; clr = 1'b0;
    duv_vld = 1'b0; ref_vld = 1'b0; duv_t = 25'd0; ref_t = 25'd0;
    m_cmp = 32'd0; m_mis = 16'd0;
    cyc(); cyc();
    snap(0, "reset", zero_v);
    snap(1, "reset", zero_v);
    rst = 1'b0;

    // Identical streams, same cycles; compare lands one edge after the push.
    step(1'b1, txn(0), 1'b1, txn(0));
    snap(0, "latency_push_edge", zero_v);
    step(1'b1, txn(1), 1'b1, txn(1));
    snap(0, "latency_next_edge", mk(32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    for (int i = 2; i < 10; i++) step(1'b1, txn(i), 1'b1, txn(i));
    idle(2);
    snap(0, "same_stream", mk(32'd10, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    snap(1, "same_stream", mk(32'd10, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    do_clr();

    // DUV trails ref by 3 cycles.
    for (int i = 0; i < 13; i++)
      step((i >= 3), txn(i - 3), (i < 10), txn(i));
    idle(3);
    snap(0, "duv_delay3", mk(32'd10, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    snap(1, "duv_delay3", mk(32'd10, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    do_clr();

    // Data mismatches on txns 4, 6 and 8 (reads at 16'h8000+i).
    for (int i = 0; i < 10; i++) begin
      r.rw = 1'b1; r.addr = 16'h8000 + 16'(i); r.data = 8'h3F + 8'(i);
      d = r;
      if (i == 4 || i == 6 || i == 8) d.data = r.data - 8'd1;
      step(1'b1, d, 1'b1, r);
    end
    idle(2);
    snap(0, "mis_halt", mk(32'd5, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd4,
                           {1'b1, 16'h8004, 8'h42}, {1'b1, 16'h8004, 8'h43}));
    snap(1, "mis_cont", mk(32'd10, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4,
                           {1'b1, 16'h8004, 8'h42}, {1'b1, 16'h8004, 8'h43}));
    do_clr();

    // Ref leads alone: timeout exactly 64 edges after the push edge.
    step(1'b0, 25'd0, 1'b1, txn(3));
    idle(63);
    snap(0, "tmo_edge63", zero_v);
    snap(1, "tmo_edge63", zero_v);
    idle(1);
    snap(0, "tmo_edge64", mk(32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 25'd0, 25'd0));
    snap(1, "tmo_edge64", mk(32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 25'd0, 25'd0));
    do_clr();

    // Ref pushes DEPTH+1 with DUV silent: ninth push overflows.
    for (int i = 0; i < 8; i++) step(1'b0, 25'd0, 1'b1, txn(i));
    snap(0, "ovf_full_only", zero_v);
    step(1'b0, 25'd0, 1'b1, txn(8));
    snap(0, "ovf_ninth", mk(32'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 25'd0, 25'd0));
    snap(1, "ovf_ninth", mk(32'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 25'd0, 25'd0));
    do_clr();
    snap(0, "after_clr", zero_v);
    snap(1, "after_clr", zero_v);

    // After clr the FIFOs must be empty and the checker running again.
    step(1'b1, txn(20), 1'b1, txn(20));
    idle(2);
    snap(0, "run_after_clr", mk(32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    snap(1, "run_after_clr", mk(32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));

    // Pushes with en low are ignored.
    en = 1'b0;
    step(1'b1, txn(30), 1'b1, txn(31));
    step(1'b1, txn(32), 1'b1, txn(33));
    en = 1'b1;
    idle(3);
    snap(0, "en_low", mk(32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    snap(1, "en_low", mk(32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 25'd0, 25'd0));
    idle(2);

    n_total++;
    if (cmp_q.size() != 0)
      $display("FAIL compare_drain: got %0d pending compares expected 0", cmp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
